// File: rtl/mcu_multi_cycle_if.sv
// Instruction and data memory buses of the multi-cycle MCU.
// Both buses use a req/ready handshake with arbitrary wait states.
interface mcu_multi_cycle_if #(
   parameter int DATA_W  = 16,
   parameter int PC_W    = 16,
   parameter int DADDR_W = 8
);
   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic [15:0]        imem_rdata;
   logic               imem_ready;
   logic               dmem_req;
   logic               dmem_we;
   logic [DADDR_W-1:0] dmem_addr;
   logic [DATA_W-1:0]  dmem_wdata;
   logic [DATA_W-1:0]  dmem_rdata;
   logic               dmem_ready;

   modport master (
      output imem_req, imem_addr,
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  imem_rdata, imem_ready,
      input  dmem_rdata, dmem_ready
   );

   modport slave (
      input  imem_req, imem_addr,
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output imem_rdata, imem_ready,
      output dmem_rdata, dmem_ready
   );
endinterface

// File: rtl/mcu_multi_cycle.sv
// Multi-cycle 16-bit-instruction MCU: FETCH/DECODE/EXEC/MEM/WB sequencer
// with external instruction and data memories behind req/ready buses.
module mcu_multi_cycle #(
   parameter int DATA_W  = 16,
   parameter int PC_W    = 16,
   parameter int DADDR_W = 8
) (
   input  logic                clk,
   input  logic                Clear,
   mcu_multi_cycle_if.master   bus,
   output logic [DATA_W-1:0]   reg1,
   output logic                retired,
   output logic                halted
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   state_t            state;
   logic [PC_W-1:0]   pc;
   logic [15:0]       ir;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic [DATA_W-1:0] alu_out;
   logic [DATA_W-1:0] mdr;
   logic [DATA_W-1:0] rf [16];
   logic              ireq;
   logic              dreq;
   logic              dwe;

   logic [3:0]        op;
   logic [3:0]        rs;
   logic [3:0]        rt;
   logic [3:0]        rd;
   logic [3:0]        dest;
   logic [DATA_W-1:0] imm_d;
   logic [PC_W-1:0]   imm_p;
   logic [DATA_W-1:0] alu_res;
   logic [DATA_W-1:0] wb_data;
   logic              is_r;
   logic              is_addi;
   logic              is_lw;
   logic              is_sw;
   logic              is_beq;
   logic              is_j;
   logic              is_halt;
   logic              to_wb;
   logic              is_mem;
   logic              slt;

   assign op = ir[15:12];
   assign rs = ir[11:8];
   assign rt = ir[7:4];
   assign rd = ir[3:0];

   assign imm_d = {{(DATA_W-4){ir[3]}}, ir[3:0]};
   assign imm_p = {{(PC_W-4){ir[3]}}, ir[3:0]};

   assign is_r    = op < 4'd5;
   assign is_addi = op == 4'd5;
   assign is_lw   = op == 4'd6;
   assign is_sw   = op == 4'd7;
   assign is_beq  = op == 4'd8;
   assign is_j    = op == 4'd9;
   assign is_halt = op == 4'hF;
   assign to_wb   = is_r | is_addi;
   assign is_mem  = is_lw | is_sw;

   assign slt = $signed(a) < $signed(b);

   always_comb begin
      alu_res = a + imm_d;
      unique case (op)
         4'd0:    alu_res = a + b;
         4'd1:    alu_res = a - b;
         4'd2:    alu_res = a & b;
         4'd3:    alu_res = a | b;
         4'd4:    alu_res = {{(DATA_W-1){1'b0}}, slt};
         default: alu_res = a + imm_d;
      endcase
   end

   assign dest    = is_r ? rd : rt;
   assign wb_data = is_lw ? mdr : alu_out;

   // Memory bus outputs come straight from registered state.
   assign bus.imem_req   = ireq;
   assign bus.imem_addr  = pc;
   assign bus.dmem_req   = dreq;
   assign bus.dmem_we    = dwe;
   assign bus.dmem_addr  = alu_out[DADDR_W-1:0];
   assign bus.dmem_wdata = b;

   // High in the final cycle of each instruction.
   assign retired = (state == S_WB)
                  | (state == S_EXEC && !(to_wb | is_mem))
                  | (state == S_MEM && is_sw && bus.dmem_ready);

   always_ff @(posedge clk or posedge Clear) begin
      if (Clear) begin
         state   <= S_FETCH;
         pc      <= '0;
         ir      <= '0;
         a       <= '0;
         b       <= '0;
         alu_out <= '0;
         mdr     <= '0;
         ireq    <= 1'b0;
         dreq    <= 1'b0;
         dwe     <= 1'b0;
         halted  <= 1'b0;
         reg1    <= '0;
         for (int i = 0; i < 16; i++) rf[i] <= '0;
      end else begin
         reg1 <= rf[1];
         unique case (state)
            S_FETCH: begin
               if (!ireq) begin
                  ireq <= 1'b1;
               end else if (bus.imem_ready) begin
                  ir    <= bus.imem_rdata;
                  pc    <= pc + PC_W'(1);
                  ireq  <= 1'b0;
                  state <= S_DECODE;
               end
            end
            S_DECODE: begin
               a     <= rf[rs];
               b     <= rf[rt];
               state <= S_EXEC;
            end
            S_EXEC: begin
               alu_out <= alu_res;
               unique case (1'b1)
                  to_wb: state <= S_WB;
                  is_mem: begin
                     dreq  <= 1'b1;
                     dwe   <= is_sw;
                     state <= S_MEM;
                  end
                  is_beq: begin
                     if (a == b) pc <= pc + imm_p;
                     ireq  <= 1'b1;
                     state <= S_FETCH;
                  end
                  is_j: begin
                     pc    <= {pc[PC_W-1:12], ir[11:0]};
                     ireq  <= 1'b1;
                     state <= S_FETCH;
                  end
                  is_halt: begin
                     halted <= 1'b1;
                     state  <= S_HALT;
                  end
                  default: begin
                     ireq  <= 1'b1;
                     state <= S_FETCH;
                  end
               endcase
            end
            S_MEM: begin
               if (bus.dmem_ready) begin
                  dreq <= 1'b0;
                  dwe  <= 1'b0;
                  if (is_lw) begin
                     mdr   <= bus.dmem_rdata;
                     state <= S_WB;
                  end else begin
                     ireq  <= 1'b1;
                     state <= S_FETCH;
                  end
               end
            end
            S_WB: begin
               rf[dest] <= wb_data;
               ireq     <= 1'b1;
               state    <= S_FETCH;
            end
            S_HALT: state <= S_HALT;
            default: state <= S_FETCH;
         endcase
      end
   end

endmodule
